prog_mem: RTL and testbench

//  Program memory feeding the CPU's instruction input: CPU drives addr, this block returns data.

---
 rtl/prog_mem.sv | 100 ++++++++++
 tb/tb_prog_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// Program memory with a host loader stream, zero-fill of unloaded words
// and a CPU reset that is released only once the whole image is in place.
module prog_mem #(
   parameter int ADDR_W = 1,
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic              reload,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              cpu_n_reset,
   output logic [ADDR_W:0]   loaded
);

   localparam int DEPTH = 2**ADDR_W;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              at_end;
   logic              we;
   logic [DATA_W-1:0] wdata;

   assign ld_ready    = (state == S_LOAD);
   assign cpu_n_reset = (state == S_RUN);
   assign accept      = ld_valid & ld_ready;
   assign at_end      = &wr_ptr;
   assign data        = cpu_n_reset ? mem[addr] : '0;

   // The loader and the zero-fill share the one write port.
   always_comb begin
      we    = 1'b0;
      wdata = '0;
      if (accept) begin
         we    = 1'b1;
         wdata = ld_data;
      end else if (state == S_FILL) begin
         we    = 1'b1;
      end
   end

   // No reset on the array; stale words are cleared by FILL instead.
   always_ff @(posedge clk) begin
      if (!reset && we) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_LOAD;
         wr_ptr <= '0;
         loaded <= '0;
      end else begin
         unique case (state)
            S_LOAD: begin
               if (ld_valid) begin
                  loaded <= loaded + 1'b1;
                  wr_ptr <= wr_ptr + 1'b1;
                  if (at_end) begin
                     state <= S_RUN;
                  end else if (ld_last) begin
                     state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               wr_ptr <= wr_ptr + 1'b1;
               if (at_end) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (reload) begin
                  state  <= S_LOAD;
                  wr_ptr <= '0;
                  loaded <= '0;
               end
            end
            default: begin
               state  <= S_LOAD;
               wr_ptr <= '0;
               loaded <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: directed scenarios plus random traffic, all
// checked each cycle against an image-level model of the memory.
module tb_prog_mem;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_valid;
   logic          ld_ready;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          reload;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          cpu_n_reset;
   logic [AW:0]   loaded;

   int errors = 0;
   int checks = 0;

   prog_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk),
      .reset(reset),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_data(ld_data),
      .ld_last(ld_last),
      .reload(reload),
      .addr(addr),
      .data(data),
      .cpu_n_reset(cpu_n_reset),
      .loaded(loaded)
   );

   always #5 clk = ~clk;

   // Model: the image is the list of accepted words; anything past it reads 0.
   logic [DW-1:0] img [$];
   bit m_loading;
   bit m_run;
   int m_fill;
   int m_loaded;
   int edges = 0;

   always @(posedge clk) begin
      edges++;
      if (reset) begin
         m_loading = 1; m_run = 0; m_fill = 0; m_loaded = 0;
         img.delete();
      end else if (m_loading) begin
         if (ld_valid) begin
            img.push_back(ld_data);
            m_loaded++;
            if (ld_last || m_loaded == DEPTH) begin
               m_loading = 0;
               m_fill = DEPTH - m_loaded;
               m_run = (m_fill == 0);
            end
         end
      end else if (m_fill > 0) begin
         m_fill--;
         if (m_fill == 0) m_run = 1;
      end else if (m_run && reload) begin
         m_run = 0; m_loading = 1; m_loaded = 0;
         img.delete();
      end
   end

   function automatic logic [DW-1:0] exp_data(int a);
      if (!m_run) return '0;
      if (a < m_loaded) return img[a];
      return '0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (edges > 0) begin
         chk("m_ready", 32'(ld_ready), 32'(m_loading));
         chk("m_cpu_n_reset", 32'(cpu_n_reset), 32'(m_run));
         chk("m_loaded", 32'(loaded), 32'(m_loaded));
         chk("m_data", 32'(data), 32'(exp_data(int'(addr))));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(logic [DW-1:0] d, logic last);
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      cyc();
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic peek(string name, int a, logic [DW-1:0] exp);
      addr = AW'(a);
      #1;
      chk(name, 32'(data), 32'(exp));
   endtask

   initial begin
      reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      reload = 1'b0; addr = '0;
      cyc(); cyc();
      reset = 1'b0;
      chk("rst_ready", 32'(ld_ready), 32'd1);
      chk("rst_cpu", 32'(cpu_n_reset), 32'd0);
      chk("rst_loaded", 32'(loaded), 32'd0);
      chk("rst_data", 32'(data), 32'd0);

      // Two beats, last on the second; two fill cycles follow.
      beat(8'h01, 1'b0);
      beat(8'h00, 1'b1);
      chk("t1_fill_ready", 32'(ld_ready), 32'd0);
      chk("t1_fill_cpu", 32'(cpu_n_reset), 32'd0);
      cyc();
      chk("t1_fill2_cpu", 32'(cpu_n_reset), 32'd0);
      cyc();
      chk("t1_run_cpu", 32'(cpu_n_reset), 32'd1);
      chk("t1_loaded", 32'(loaded), 32'd2);
      peek("t1_a0", 0, 8'h01);
      peek("t1_a1", 1, 8'h00);
      peek("t1_a3", 3, 8'h00);

      // Beat offered in RUN has no effect.
      beat(8'h77, 1'b1);
      chk("t3_run_loaded", 32'(loaded), 32'd2);

      // Reload, then overrun: five beats offered, four taken.
      reload = 1'b1; cyc(); reload = 1'b0;
      chk("t5_cpu", 32'(cpu_n_reset), 32'd0);
      chk("t5_loaded", 32'(loaded), 32'd0);
      chk("t5_ready", 32'(ld_ready), 32'd1);
      chk("t5_data", 32'(data), 32'd0);
      ld_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ld_data = 8'hAA + 8'(i * 17);
         cyc();
      end
      chk("t4_cpu", 32'(cpu_n_reset), 32'd1);
      chk("t4_ready", 32'(ld_ready), 32'd0);
      ld_data = 8'h55;
      cyc();
      ld_valid = 1'b0;
      chk("t4_loaded", 32'(loaded), 32'd4);
      peek("t4_a1", 1, 8'hBB);
      peek("t4_a3", 3, 8'hDD);

      // Short image over old contents; reload during FILL is ignored.
      reload = 1'b1; cyc(); reload = 1'b0;
      beat(8'h01, 1'b1);
      reload = 1'b1; cyc(); reload = 1'b0;
      chk("t2_fill_cpu", 32'(cpu_n_reset), 32'd0);
      cyc();
      chk("t2_fill2_cpu", 32'(cpu_n_reset), 32'd0);
      cyc();
      chk("t2_run_cpu", 32'(cpu_n_reset), 32'd1);
      chk("t2_loaded", 32'(loaded), 32'd1);
      peek("t2_a0", 0, 8'h01);
      peek("t2_a1", 1, 8'h00);
      peek("t2_a3", 3, 8'h00);

      // Bubble between beats: only two writes.
      reload = 1'b1; cyc(); reload = 1'b0;
      ld_data = 8'h31; ld_valid = 1'b1; cyc();
      ld_valid = 1'b0; cyc();
      chk("t3_bubble_loaded", 32'(loaded), 32'd1);
      ld_data = 8'h32; ld_valid = 1'b1; ld_last = 1'b1; cyc();
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("t3_loaded", 32'(loaded), 32'd2);
      cyc(); cyc();

      // Reset after the first of two beats.
      reload = 1'b1; cyc(); reload = 1'b0;
      beat(8'h44, 1'b0);
      reset = 1'b1; ld_valid = 1'b1; ld_data = 8'h99; cyc();
      reset = 1'b0; ld_valid = 1'b0;
      chk("t6_ready", 32'(ld_ready), 32'd1);
      chk("t6_loaded", 32'(loaded), 32'd0);
      chk("t6_cpu", 32'(cpu_n_reset), 32'd0);
      beat(8'h5A, 1'b0);
      beat(8'hA5, 1'b1);
      cyc(); cyc();
      chk("t6_run_cpu", 32'(cpu_n_reset), 32'd1);
      peek("t6_a0", 0, 8'h5A);
      peek("t6_a1", 1, 8'hA5);
      peek("t6_a2", 2, 8'h00);

      // Random traffic; the negedge process does the checking.
      for (int i = 0; i < 3000; i++) begin
         ld_valid = ($urandom_range(0, 9) < 6);
         ld_data  = DW'($urandom);
         ld_last  = ($urandom_range(0, 4) == 0);
         reload   = ($urandom_range(0, 9) == 0);
         reset    = ($urandom_range(0, 49) == 0);
         addr     = AW'($urandom);
         cyc();
      end
      reset = 1'b0; ld_valid = 1'b0; reload = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
